// File: rtl/mem_arb_pkg.sv
// +------------------------------------------------------------------------+
// | mem_arb_pkg                                                            |
// | Shared types for the CPU/host unified-memory arbiter: access FSM state |
// | encoding and the access-owner encoding.                                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  // One cycle per state except IDLE, which waits for a request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/arb_picker.sv
// +------------------------------------------------------------------------+
// | arb_picker                                                             |
// | Combinational winner selection between the CPU and host requesters.   |
// | Policy macro: MEM_ARB_RR_EN                                            |
// |   defined   - round-robin, the requester that did not win last wins a  |
// |               tie                                                      |
// |   undefined - fixed priority, host wins a tie; last_winner is ignored  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module arb_picker
  import mem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   host_req,
  input  owner_e last_winner,
  output owner_e owner
);

`ifdef MEM_ARB_RR_EN
  // Tie goes to whoever did not win the previous grant.
  always_comb begin
    owner = OWN_HOST;
    if (cpu_req && host_req) begin
      owner = (last_winner == OWN_HOST) ? OWN_CPU : OWN_HOST;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end
  end
`else
  // Host is the loader/debug path and always takes precedence.
  logic unused_last;
  assign unused_last = (last_winner == OWN_HOST);

  always_comb begin
    owner = OWN_CPU;
    if (host_req) begin
      owner = OWN_HOST;
    end
  end
`endif

endmodule : arb_picker

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +------------------------------------------------------------------------+
// | mem_arbiter                                                            |
// | Two-port (CPU, host) arbiter onto a single-cycle unified memory.      |
// | Each access runs IDLE -> ACCESS -> RESP -> DONE; ack pulses in DONE.  |
// | Policy macro: MEM_ARB_RR_EN (round-robin when defined, host-priority  |
// | otherwise; the last-winner register exists only in round-robin).      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  owner_e            pick;
  owner_e            last_sel;

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;
  assign last_sel = last_q;
`else
  assign last_sel = OWN_HOST;
`endif

  arb_picker u_picker (
    .cpu_req     (cpu_req),
    .host_req    (host_req),
    .last_winner (last_sel),
    .owner       (pick)
  );

  // Next-state, grant latching and read-data capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req || host_req) begin
          owner_d = pick;
          state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
          last_d  = pick;
`endif
          if (pick == OWN_HOST) begin
            we_d        = host_we;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
          end else begin
            we_d        = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        // Memory data is valid the cycle after the address cycle; capture
        // it for writes too so the owner always sees the memory response.
        state_d = DONE;
        if (owner_q == OWN_HOST) begin
          host_rdata_d = mem_rdata;
        end else begin
          cpu_rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_HOST;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-winner history for the round-robin tie break.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_HOST;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Strobes decode straight from registered state, so reset clears them at once.
  assign mem_we     = (state_q == ACCESS) && we_q;
  assign cpu_ack    = (state_q == DONE) && (owner_q == OWN_CPU);
  assign host_ack   = (state_q == DONE) && (owner_q == OWN_HOST);
  assign cpu_stall  = cpu_req & ~cpu_ack;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_mem_arbiter                                                         |
// | Self-checking bench for mem_arbiter with a timeline-based reference   |
// | model. Honors MEM_ARB_RR_EN the same way as the design.               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata, mem_rdata;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata;
  logic        cpu_ack, cpu_stall, host_ack, mem_we;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a grant at cycle g means write strobe at g+1, data
  // capture at g+2, ack at g+3, and the arbiter is free again at g+4.
  int          cyc = 0;
  bit          m_active;
  int          m_g;
  bit          m_host;
  bit          m_we;
  bit          m_last_host;
  logic [31:0] m_addr, m_wdata, m_crd, m_hrd;
  logic        e_mwe, e_cack, e_hack;

  always @(negedge clk) begin
    cyc++;
    if (rst !== 1'b1) begin
      m_active    = 1'b0;
      m_addr      = '0;
      m_wdata     = '0;
      m_crd       = '0;
      m_hrd       = '0;
      m_last_host = 1'b1;
      e_mwe       = 1'b0;
      e_cack      = 1'b0;
      e_hack      = 1'b0;
    end else begin
      e_mwe  = m_active && (cyc == m_g + 1) && m_we;
      e_cack = m_active && (cyc == m_g + 3) && !m_host;
      e_hack = m_active && (cyc == m_g + 3) && m_host;
    end
    chk("mem_we", mem_we, e_mwe);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("cpu_ack", cpu_ack, e_cack);
    chk("host_ack", host_ack, e_hack);
    chk("cpu_rdata", cpu_rdata, m_crd);
    chk("host_rdata", host_rdata, m_hrd);
    chk("cpu_stall", cpu_stall, cpu_req & ~e_cack);
    if (rst === 1'b1) begin
      if (m_active && (cyc == m_g + 2)) begin
        if (m_host) m_hrd = mem_rdata;
        else        m_crd = mem_rdata;
      end
      if (m_active && (cyc == m_g + 3)) begin
        m_active = 1'b0;
      end else if (!m_active && (cpu_req || host_req)) begin
        if (cpu_req && host_req) begin
`ifdef MEM_ARB_RR_EN
          m_host = !m_last_host;
`else
          m_host = 1'b1;
`endif
        end else begin
          m_host = host_req;
        end
        m_active    = 1'b1;
        m_g         = cyc;
        m_last_host = m_host;
        m_we        = m_host ? host_we : cpu_we;
        m_addr      = m_host ? host_addr : cpu_addr;
        m_wdata     = m_host ? host_wdata : cpu_wdata;
      end
    end
  end

  initial begin
    int we_cnt;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_rdata = '0;
    step();
    step();
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_we", mem_we, 32'h0);

    // CPU read of 0x40, memory returns 0xDEADBEEF; request cycle N is now.
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("d1_stall_req", cpu_stall, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i < 3) begin
        chk("d1_ack_early", cpu_ack, 32'h0);
        chk("d1_stall_wait", cpu_stall, 32'h1);
      end else begin
        chk("d1_ack", cpu_ack, 32'h1);
        chk("d1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("d1_host_ack", host_ack, 32'h0);
        chk("d1_stall_ack", cpu_stall, 32'h0);
      end
    end
    cpu_req = 1'b0;
    step();

    // Host write of 0x12345678 to 0x10.
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'h12345678;
    we_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (mem_we) begin
        we_cnt++;
        chk("d2_addr", mem_addr, 32'h10);
        chk("d2_wdata", mem_wdata, 32'h12345678);
      end
      chk("d2_host_ack", host_ack, (i == 3) ? 32'h1 : 32'h0);
      if (i == 3) host_req = 1'b0;
    end
    chk("d2_we_cycles", we_cnt, 32'h1);

    // Both requesters held; previous winner was the host.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h200;
    for (int i = 1; i <= 16; i++) begin
      logic ec, eh;
      step();
      ec = 1'b0;
      eh = 1'b0;
      if ((i % 4) == 3) begin
`ifdef MEM_ARB_RR_EN
        ec = ((i / 4) % 2) == 0;
        eh = !ec;
`else
        eh = 1'b1;
`endif
      end
      chk("d3_cpu_ack", cpu_ack, 32'(ec));
      chk("d3_host_ack", host_ack, 32'(eh));
    end
    cpu_req = 1'b0;
    host_req = 1'b0;
    step();
    step();

    // Reset pulsed during the ACCESS cycle of a host write.
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h20; host_wdata = 32'hA5A5A5A5;
    step();
    chk("d4_we_access", mem_we, 32'h1);
    host_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("d4_we_rst", mem_we, 32'h0);
    chk("d4_cpu_rdata", cpu_rdata, 32'h0);
    chk("d4_host_rdata", host_rdata, 32'h0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("d4_no_ack", host_ack, 32'h0);
    end

    // Randomized traffic with early drops and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      mem_rdata = $urandom;
      if (cpu_ack) begin
        cpu_req = 1'b0;
      end else if (cpu_req && ($urandom_range(0, 31) == 0)) begin
        cpu_req = 1'b0;
      end else if (!cpu_req && ($urandom_range(0, 2) == 0)) begin
        cpu_req = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
      end
      if (host_ack) begin
        host_req = 1'b0;
      end else if (host_req && ($urandom_range(0, 31) == 0)) begin
        host_req = 1'b0;
      end else if (!host_req && ($urandom_range(0, 2) == 0)) begin
        host_req = 1'b1;
        host_we = 1'($urandom_range(0, 1));
        host_addr = $urandom;
        host_wdata = $urandom;
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        cpu_req = 1'b0;
        host_req = 1'b0;
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end
    cpu_req = 1'b0;
    host_req = 1'b0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 cpu_we  input  1  CPU write (1) / read (0).
REQ-006 cpu_addr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_rdata  output  32  registered CPU read data.
REQ-009 cpu_ack  output  1  one-cycle CPU completion pulse.
REQ-010 cpu_stall  output  1  combinational cpu_req & ~cpu_ack, used to freeze the multicycle control FSM.
REQ-011 host_req  input  1  loader/debug access request, held until host_ack.
REQ-012 host_we  input  1  host write (1) / read (0).
REQ-013 host_addr  input  32  host byte address.
REQ-014 host_wdata  input  32  host write data.
REQ-015 host_rdata  output  32  registered host read data.
REQ-016 host_ack  output  1  one-cycle host completion pulse.
REQ-017 mem_addr  output  32  registered address to the unified memory.
REQ-018 mem_wdata  output  32  registered write data to memory.
REQ-019 mem_we  output  1  memory write strobe.
REQ-020 mem_rdata  input  32  memory read data, valid one cycle after the address cycle.

Function
REQ-021 SHALL implement the FSM IDLE -> ACCESS -> RESP -> DONE -> IDLE, one cycle per state except IDLE.
REQ-022 In IDLE with any request, SHALL pick a winner, latch the owner, load mem_addr/mem_wdata from the winner, and go to ACCESS; with no request, SHALL stay in IDLE.
REQ-023 mem_we SHALL be 1 only in ACCESS, and only when the owner's we was 1 at grant.
REQ-024 In RESP, SHALL capture mem_rdata into the owner's rdata register at the clock edge; the non-owner rdata SHALL hold its value. This capture also occurs for writes.
REQ-025 In DONE, SHALL assert the owner's ack for exactly one cycle; the next arbitration SHALL occur no earlier than the following IDLE cycle.
REQ-026 Latency: a request sampled in IDLE at cycle N SHALL produce its ack in cycle N+3; peak throughput SHALL be one access per 4 cycles.
REQ-027 Simultaneous requests SHALL be resolved per REQ-033/034.
REQ-028 Requests that drop after grant SHALL NOT abort the access; the access SHALL complete and ack SHALL still pulse.
REQ-029 Address and data SHALL pass unmodified (no alignment check).

Reset
REQ-030 On rst low, SHALL go immediately to IDLE with mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=0, host_ack=0, cpu_rdata=0, host_rdata=0 and last-winner=HOST.
REQ-031 Reset asserted mid-access SHALL abort the access with no ack issued.

Configuration
REQ-032 Macro MEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-033 MEM_ARB_RR_EN defined: round-robin; on a tie, the requester that did not win last SHALL win; last-winner SHALL update at each grant.
REQ-034 MEM_ARB_RR_EN undefined: fixed priority, host always wins a tie; the last-winner register SHALL be absent.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP, DONE) and the owner enum (OWN_CPU, OWN_HOST).
REQ-036 Winner selection SHALL be a combinational sub-module arb_picker (inputs: both requests and last-winner; output: owner).

Verification
REQ-037 CPU read only, addr 0x40, mem returns 0xDEADBEEF -> cpu_ack in cycle N+3, cpu_rdata=0xDEADBEEF, host_ack stays 0.
REQ-038 Host write, addr 0x10, data 0x12345678 -> mem_we=1 for exactly one cycle, with mem_addr=0x10 and mem_wdata=0x12345678; host_ack at N+3.
REQ-039 Both requests held continuously, RR_EN defined -> grants alternate CPU, HOST, CPU, HOST with acks 4 cycles apart; RR_EN undefined -> host granted every time.
REQ-040 rst pulsed low during ACCESS of a write -> mem_we drops asynchronously, no ack, FSM in IDLE, rdata outputs 0.
REQ-041 cpu_req high and un-acked -> cpu_stall=1 in every cycle; cpu_stall=0 in the cpu_ack cycle.
